// File: rtl/fft_out_reorder_pkg.sv
// Shared constants, complex word layout, write-side state encoding and
// bit-reversal helper for the 16-point FFT output reorder stage.
package fft_out_reorder_pkg;

  localparam int FFT_LOG2N = 4;
  localparam int FFT_N     = 1 << FFT_LOG2N;
  localparam int FFT_WL    = 16;

  // Stored word: real part in the MSBs, imaginary part in the LSBs.
  typedef struct packed {
    logic [FFT_WL-1:0] re;
    logic [FFT_WL-1:0] im;
  } cplx_t;

  // WR_DROP marks a frame that found its target bank still occupied.
  typedef enum logic {
    WR_KEEP = 1'b0,
    WR_DROP = 1'b1
  } wr_state_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] v);
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++) begin
      r[i] = v[FFT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// Two-bank x N-entry complex-word register file: one synchronous write port,
// one combinational read port; contents are don't-care until written.
module reorder_bank
  import fft_out_reorder_pkg::*;
#(
  parameter int WL    = FFT_WL,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wbank,
  input  logic [LOG2N-1:0]  waddr,
  input  logic [2*WL-1:0]   wdata,
  input  logic              rbank,
  input  logic [LOG2N-1:0]  raddr,
  output logic [2*WL-1:0]   rdata
);

  localparam int N = 1 << LOG2N;

  logic [2*WL-1:0] mem [2][N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wbank][waddr] <= wdata;
    end
  end

  assign rdata = mem[rbank][raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder of bit-reversed FFT frames into natural order; first word one
// cycle after a frame completes, one word/cycle; iREADY low holds the output, full banks drop frames.
module fft_out_reorder
  import fft_out_reorder_pkg::*;
#(
  parameter int WL     = FFT_WL,
  parameter int LOG2N  = FFT_LOG2N,
  parameter int BITREV = 1
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iCLR,
  input  logic              iEN,
  input  logic [WL-1:0]     iDATA_re,
  input  logic [WL-1:0]     iDATA_im,
  input  logic              iREADY,
  output logic              oVALID,
  output logic [WL-1:0]     oDATA_re,
  output logic [WL-1:0]     oDATA_im,
  output logic [LOG2N-1:0]  oINDEX,
  output logic              oSOF,
  output logic              oEOF,
  output logic              oOVF
);

  localparam logic [LOG2N-1:0] CNT_ONE  = 1;
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  wr_state_t         wr_state, wr_state_nxt;
  logic [LOG2N-1:0]  wcnt, rcnt;
  logic              wb, rb;
  logic [1:0]        full, full_nxt;

  logic              frame_start, frame_last, drop_cur;
  logic              wr_en, set_full;
  logic [LOG2N-1:0]  waddr;
  logic [2*WL-1:0]   wdata, rdata;
  logic              load, rd_last, clr_full;

  assign frame_start = (wcnt == '0);
  assign frame_last  = (wcnt == CNT_LAST);
  // The drop decision for a frame is made on its first sample and then latched in wr_state.
  assign drop_cur    = frame_start ? full[wb] : (wr_state == WR_DROP);
  assign waddr       = (BITREV != 0) ? bitrev(wcnt) : wcnt;
  assign wdata       = {iDATA_re, iDATA_im};

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      wr_state <= WR_KEEP;
    end else if (iCLR) begin
      wr_state <= WR_KEEP;
    end else begin
      wr_state <= wr_state_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_en        = 1'b0;
    set_full     = 1'b0;
    if (iEN) begin
      wr_en = !drop_cur;
      if (frame_last) begin
        set_full     = !drop_cur;
        wr_state_nxt = WR_KEEP;
      end else if (frame_start) begin
        wr_state_nxt = drop_cur ? WR_DROP : WR_KEEP;
      end
    end
  end

  assign load     = full[rb] && (!oVALID || iREADY);
  assign rd_last  = (rcnt == CNT_LAST);
  assign clr_full = load && rd_last;

  // Set and clear always target different banks: a bank is only written while empty.
  always_comb begin
    full_nxt = full;
    if (set_full) begin
      full_nxt[wb] = 1'b1;
    end
    if (clr_full) begin
      full_nxt[rb] = 1'b0;
    end
  end

  reorder_bank #(
    .WL    (WL),
    .LOG2N (LOG2N)
  ) u_bank (
    .clk   (iCLK),
    .we    (wr_en),
    .wbank (wb),
    .waddr (waddr),
    .wdata (wdata),
    .rbank (rb),
    .raddr (rcnt),
    .rdata (rdata)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      wcnt     <= '0;
      rcnt     <= '0;
      wb       <= 1'b0;
      rb       <= 1'b0;
      full     <= '0;
      oVALID   <= 1'b0;
      oDATA_re <= '0;
      oDATA_im <= '0;
      oINDEX   <= '0;
      oSOF     <= 1'b0;
      oEOF     <= 1'b0;
      oOVF     <= 1'b0;
    end else if (iCLR) begin
      wcnt     <= '0;
      rcnt     <= '0;
      wb       <= 1'b0;
      rb       <= 1'b0;
      full     <= '0;
      oVALID   <= 1'b0;
      oDATA_re <= '0;
      oDATA_im <= '0;
      oINDEX   <= '0;
      oSOF     <= 1'b0;
      oEOF     <= 1'b0;
      oOVF     <= 1'b0;
    end else begin
      full <= full_nxt;
      if (iEN) begin
        wcnt <= wcnt + CNT_ONE;
        if (set_full) begin
          wb <= ~wb;
        end
        if (frame_start && full[wb]) begin
          oOVF <= 1'b1;
        end
      end
      if (load) begin
        oVALID   <= 1'b1;
        oDATA_re <= rdata[2*WL-1:WL];
        oDATA_im <= rdata[WL-1:0];
        oINDEX   <= rcnt;
        oSOF     <= (rcnt == '0);
        oEOF     <= rd_last;
        rcnt     <= rcnt + CNT_ONE;
        if (rd_last) begin
          rb <= ~rb;
        end
      end else if (oVALID && iREADY) begin
        oVALID <= 1'b0;
        oINDEX <= '0;
        oSOF   <= 1'b0;
        oEOF   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed self-checking bench for fft_out_reorder: ordering, backpressure,
// ping-pong, overflow, clear and gapped input with asynchronous reset.
module tb_fft_out_reorder;

  logic        iCLK, iRSTn, iCLR, iEN, iREADY;
  logic [15:0] iDATA_re, iDATA_im;
  logic        oVALID, oSOF, oEOF, oOVF;
  logic [15:0] oDATA_re, oDATA_im;
  logic [3:0]  oINDEX;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int exp_br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic [15:0] q_re[$];
  logic [15:0] q_im[$];
  logic [3:0]  q_idx[$];
  logic        q_sof[$];
  logic        q_eof[$];
  int          q_cyc[$];

  fft_out_reorder #(.WL(16), .LOG2N(4), .BITREV(1)) dut (
    .iCLK     (iCLK),
    .iRSTn    (iRSTn),
    .iCLR     (iCLR),
    .iEN      (iEN),
    .iDATA_re (iDATA_re),
    .iDATA_im (iDATA_im),
    .iREADY   (iREADY),
    .oVALID   (oVALID),
    .oDATA_re (oDATA_re),
    .oDATA_im (oDATA_im),
    .oINDEX   (oINDEX),
    .oSOF     (oSOF),
    .oEOF     (oEOF),
    .oOVF     (oOVF)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc++;

  // Record every word that the next rising edge will accept.
  always @(negedge iCLK) begin
    if (oVALID === 1'b1 && iREADY === 1'b1) begin
      q_re.push_back(oDATA_re);
      q_im.push_back(oDATA_im);
      q_idx.push_back(oINDEX);
      q_sof.push_back(oSOF);
      q_eof.push_back(oEOF);
      q_cyc.push_back(cyc);
    end
  end

  task automatic wait_cycle();
    @(posedge iCLK);
    #1;
  endtask

  task automatic clear_queues();
    q_re.delete(); q_im.delete(); q_idx.delete();
    q_sof.delete(); q_eof.delete(); q_cyc.delete();
  endtask

  task automatic send_stream(input int nfr, input int base0, input int step, input int gap);
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < 16; k++) begin
        wait_cycle();
        iEN      = 1'b1;
        iDATA_re = 16'(base0 + step * f + k);
        iDATA_im = 16'(-(base0 + step * f + k));
        for (int g = 1; g < gap; g++) begin
          wait_cycle();
          iEN = 1'b0;
        end
      end
    end
    wait_cycle();
    iEN = 1'b0;
  endtask

  task automatic test_reset();
    iRSTn = 1'b1; iCLR = 1'b0; iEN = 1'b0; iREADY = 1'b0;
    iDATA_re = '0; iDATA_im = '0;
    #1 iRSTn = 1'b0;
    #2;
    checks++;
    if ({oVALID, oDATA_re, oDATA_im, oINDEX, oSOF, oEOF, oOVF} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b re=%h im=%h idx=%h sof=%b eof=%b ovf=%b, want all 0",
               oVALID, oDATA_re, oDATA_im, oINDEX, oSOF, oEOF, oOVF);
    end
    repeat (2) @(posedge iCLK);
    @(negedge iCLK) iRSTn = 1'b1;
    wait_cycle();
    checks++;
    if (oVALID !== 1'b0 || oOVF !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got v=%b ovf=%b, want 0 0", oVALID, oOVF);
    end
  endtask

  task automatic test_ordering();
    iREADY = 1'b1;
    clear_queues();
    send_stream(1, 0, 0, 1);
    checks++;
    if (oVALID !== 1'b0) begin
      errors++;
      $display("FAIL order_latency_early: got v=%b, want 0 at last-sample edge", oVALID);
    end
    wait_cycle();
    checks++;
    if (oVALID !== 1'b1 || oINDEX !== 4'd0 || oSOF !== 1'b1 || oDATA_re !== 16'd0) begin
      errors++;
      $display("FAIL order_first_word: got v=%b idx=%0d sof=%b re=%0d, want 1 0 1 0",
               oVALID, oINDEX, oSOF, oDATA_re);
    end
    repeat (20) wait_cycle();
    checks++;
    if (q_re.size() != 16) begin
      errors++;
      $display("FAIL order_count: got %0d words, want 16", q_re.size());
    end
    for (int i = 0; i < 16 && i < q_re.size(); i++) begin
      checks++;
      if (q_re[i] !== 16'(exp_br[i]) || q_im[i] !== 16'(-exp_br[i]) || q_idx[i] !== 4'(i) ||
          q_sof[i] !== (i == 0) || q_eof[i] !== (i == 15)) begin
        errors++;
        $display("FAIL order_word%0d: got re=%0d im=%h idx=%0d sof=%b eof=%b, want re=%0d im=%h idx=%0d",
                 i, q_re[i], q_im[i], q_idx[i], q_sof[i], q_eof[i], exp_br[i], 16'(-exp_br[i]), i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic       pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       prev_stall;
    logic [15:0] prev_re;
    logic [3:0]  prev_idx;
    int          stall_errs;
    prev_stall = 1'b0; prev_re = '0; prev_idx = '0; stall_errs = 0;
    clear_queues();
    fork
      send_stream(1, 0, 0, 1);
      begin
        for (int c = 0; c < 80; c++) begin
          wait_cycle();
          iREADY = pat[c % 4];
          @(negedge iCLK);
          if (prev_stall) begin
            checks++;
            if (oVALID !== 1'b1 || oDATA_re !== prev_re || oINDEX !== prev_idx) begin
              errors++;
              stall_errs++;
              $display("FAIL bp_stall_hold cycle %0d: got v=%b re=%0d idx=%0d, want 1 %0d %0d",
                       c, oVALID, oDATA_re, oINDEX, prev_re, prev_idx);
            end
          end
          prev_stall = oVALID && !iREADY;
          prev_re    = oDATA_re;
          prev_idx   = oINDEX;
        end
      end
    join
    iREADY = 1'b1;
    checks++;
    if (q_re.size() != 16) begin
      errors++;
      $display("FAIL bp_count: got %0d words, want 16", q_re.size());
    end
    for (int i = 0; i < 16 && i < q_re.size(); i++) begin
      checks++;
      if (q_re[i] !== 16'(exp_br[i]) || q_idx[i] !== 4'(i)) begin
        errors++;
        $display("FAIL bp_word%0d: got re=%0d idx=%0d, want re=%0d idx=%0d",
                 i, q_re[i], q_idx[i], exp_br[i], i);
      end
    end
  endtask

  task automatic test_pingpong();
    iREADY = 1'b1;
    repeat (3) wait_cycle();
    clear_queues();
    send_stream(2, 0, 100, 1);
    repeat (40) wait_cycle();
    checks++;
    if (q_re.size() != 32) begin
      errors++;
      $display("FAIL pp_count: got %0d words, want 32", q_re.size());
    end else begin
      checks++;
      if (q_cyc[31] - q_cyc[0] != 31) begin
        errors++;
        $display("FAIL pp_contiguous: got span %0d cycles, want 31", q_cyc[31] - q_cyc[0]);
      end
    end
    for (int i = 0; i < 32 && i < q_re.size(); i++) begin
      checks++;
      if (q_re[i] !== 16'(100 * (i / 16) + exp_br[i % 16]) || q_idx[i] !== 4'(i % 16) ||
          q_sof[i] !== (i % 16 == 0)) begin
        errors++;
        $display("FAIL pp_word%0d: got re=%0d idx=%0d sof=%b, want re=%0d idx=%0d",
                 i, q_re[i], q_idx[i], q_sof[i], 100 * (i / 16) + exp_br[i % 16], i % 16);
      end
    end
  endtask

  task automatic test_overflow();
    iREADY = 1'b0;
    repeat (2) wait_cycle();
    clear_queues();
    send_stream(2, 0, 100, 1);
    checks++;
    if (oOVF !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: got ovf=%b, want 0 before frame 3", oOVF);
    end
    for (int k = 0; k < 16; k++) begin
      wait_cycle();
      if (k == 1) begin
        checks++;
        if (oOVF !== 1'b1) begin
          errors++;
          $display("FAIL ovf_set: got ovf=%b, want 1 after first sample of frame 3", oOVF);
        end
      end
      iEN      = 1'b1;
      iDATA_re = 16'(200 + k);
      iDATA_im = 16'(-(200 + k));
    end
    wait_cycle();
    iEN = 1'b0;
    iREADY = 1'b1;
    repeat (45) wait_cycle();
    checks++;
    if (q_re.size() != 32) begin
      errors++;
      $display("FAIL ovf_count: got %0d words, want 32", q_re.size());
    end
    for (int i = 0; i < 32 && i < q_re.size(); i++) begin
      checks++;
      if (q_re[i] !== 16'(100 * (i / 16) + exp_br[i % 16])) begin
        errors++;
        $display("FAIL ovf_word%0d: got re=%0d, want %0d", i, q_re[i], 100 * (i / 16) + exp_br[i % 16]);
      end
    end
    checks++;
    if (oOVF !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%b, want 1", oOVF);
    end
  endtask

  task automatic test_clear();
    iREADY = 1'b1;
    clear_queues();
    for (int k = 0; k < 7; k++) begin
      wait_cycle();
      iEN = 1'b1; iDATA_re = 16'(50 + k); iDATA_im = 16'(-(50 + k));
    end
    wait_cycle();
    iEN = 1'b0; iCLR = 1'b1;
    wait_cycle();
    iCLR = 1'b0;
    checks++;
    if ({oVALID, oDATA_re, oDATA_im, oINDEX, oSOF, oEOF, oOVF} !== '0) begin
      errors++;
      $display("FAIL clr_outputs: got v=%b re=%h im=%h idx=%h sof=%b eof=%b ovf=%b, want all 0",
               oVALID, oDATA_re, oDATA_im, oINDEX, oSOF, oEOF, oOVF);
    end
    send_stream(1, 200, 0, 1);
    repeat (20) wait_cycle();
    checks++;
    if (q_re.size() != 16) begin
      errors++;
      $display("FAIL clr_count: got %0d words, want 16", q_re.size());
    end
    for (int i = 0; i < 16 && i < q_re.size(); i++) begin
      checks++;
      if (q_re[i] !== 16'(200 + exp_br[i]) || q_im[i] !== 16'(-(200 + exp_br[i]))) begin
        errors++;
        $display("FAIL clr_word%0d: got re=%0d im=%h, want re=%0d", i, q_re[i], q_im[i], 200 + exp_br[i]);
      end
    end
    checks++;
    if (oOVF !== 1'b0) begin
      errors++;
      $display("FAIL clr_ovf: got ovf=%b, want 0", oOVF);
    end
  endtask

  task automatic test_gapped_async_reset();
    iREADY = 1'b1;
    clear_queues();
    send_stream(1, 0, 0, 3);
    repeat (20) wait_cycle();
    checks++;
    if (q_re.size() != 16) begin
      errors++;
      $display("FAIL gap_count: got %0d words, want 16", q_re.size());
    end
    for (int i = 0; i < 16 && i < q_re.size(); i++) begin
      checks++;
      if (q_re[i] !== 16'(exp_br[i]) || q_idx[i] !== 4'(i)) begin
        errors++;
        $display("FAIL gap_word%0d: got re=%0d idx=%0d, want re=%0d idx=%0d",
                 i, q_re[i], q_idx[i], exp_br[i], i);
      end
    end
    send_stream(1, 300, 0, 1);
    repeat (3) wait_cycle();
    checks++;
    if (oVALID !== 1'b1) begin
      errors++;
      $display("FAIL arst_streaming: got v=%b, want 1 mid-frame", oVALID);
    end
    #2 iRSTn = 1'b0;
    #1;
    checks++;
    if (oVALID !== 1'b0 || oINDEX !== 4'd0 || oDATA_re !== 16'd0) begin
      errors++;
      $display("FAIL arst_immediate: got v=%b idx=%0d re=%0d, want 0 0 0 before any edge",
               oVALID, oINDEX, oDATA_re);
    end
    @(negedge iCLK) iRSTn = 1'b1;
    repeat (3) wait_cycle();
    checks++;
    if (oVALID !== 1'b0) begin
      errors++;
      $display("FAIL arst_after: got v=%b, want 0 after reset release", oVALID);
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_backpressure();
    test_pingpong();
    test_overflow();
    test_clear();
    test_gapped_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
